// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg : state encodings, strobe bundle and defaults for the fetch and
//                execute controllers.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  localparam int unsigned c_MEM_TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'd0,
    FS_FETCH_T0 = 3'd1,
    FS_MEM_WAIT = 3'd2,
    FS_FETCH_T2 = 3'd3,
    FS_ISSUE    = 3'd4,
    FS_EXEC     = 3'd5,
    FS_BRANCH   = 3'd6,
    FS_FAULT    = 3'd7
  } fetch_state_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic pc_in;
    logic target_out;
  } strobes_t;

  // Only MEM_WAIT looks at an input; every other strobe is a pure state decode.
  function automatic strobes_t decode_strobes(input fetch_state_e state,
                                              input logic         mem_ready);
    strobes_t s;
    s = '0;
    case (state)
      FS_FETCH_T0: begin
        s.pc_out = 1'b1;
        s.mar_in = 1'b1;
        s.inc_pc = 1'b1;
      end
      FS_MEM_WAIT: begin
        s.read   = 1'b1;
        s.mdr_in = mem_ready;
      end
      FS_FETCH_T2: begin
        s.mdr_out = 1'b1;
        s.ir_in   = 1'b1;
      end
      FS_BRANCH: begin
        s.target_out = 1'b1;
        s.pc_in      = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timeout_counter.sv
// ----------------------------------------------------------------------------
// timeout_counter : memory wait counter; expire flags the LIMIT-th stalled
//                   cycle since the last clear.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic stall,
  output logic expire
);

  localparam int unsigned     c_W    = $clog2(LIMIT + 1);
  localparam logic [c_W-1:0]  c_LAST = c_W'(LIMIT - 1);
  localparam logic [c_W-1:0]  c_MAX  = c_W'(LIMIT);

  logic [c_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (stall && (r_count != c_MAX)) begin
      r_count <= r_count + c_W'(1);
    end
  end

  // The stalled cycle that brings the count to LIMIT is the expiring one.
  assign expire = stall && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer : instruction fetch/issue control FSM driving datapath
//                   strobes, with memory-timeout fault.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = c_MEM_TIMEOUT_DEFAULT
) (
  input  logic        Clock,
  input  logic        Clear_n,
  input  logic        run,
  input  logic        mem_ready,
  input  logic        exec_ready,
  input  logic        exec_done,
  input  logic        branch_taken,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        PCin,
  output logic        TargetOut,
  output logic        instr_valid,
  output logic        busy,
  output logic        fault,
  output logic [31:0] instr_count
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  strobes_t     w_strobes;
  logic [31:0]  r_instr_count;
  logic         w_wait_clear;
  logic         w_wait_stall;
  logic         w_wait_expire;

  // Held clear outside MEM_WAIT so every entry starts from zero.
  assign w_wait_clear = (r_state != FS_MEM_WAIT);
  assign w_wait_stall = (r_state == FS_MEM_WAIT) && !mem_ready;

  timeout_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_counter (
    .clk    (Clock),
    .rst_n  (Clear_n),
    .clear  (w_wait_clear),
    .stall  (w_wait_stall),
    .expire (w_wait_expire)
  );

  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_strobes    = decode_strobes(r_state, mem_ready);
    case (r_state)
      FS_IDLE:     if (run) w_state_next = FS_FETCH_T0;
      FS_FETCH_T0: w_state_next = FS_MEM_WAIT;
      FS_MEM_WAIT: begin
        if (mem_ready) begin
          w_state_next = FS_FETCH_T2;
        end else if (w_wait_expire) begin
          w_state_next = FS_FAULT;
        end
      end
      FS_FETCH_T2: w_state_next = FS_ISSUE;
      FS_ISSUE:    if (exec_ready) w_state_next = FS_EXEC;
      FS_EXEC: begin
        if (exec_done) begin
          if (branch_taken) begin
            w_state_next = FS_BRANCH;
          end else begin
            w_state_next = run ? FS_FETCH_T0 : FS_IDLE;
          end
        end
      end
      FS_BRANCH:   w_state_next = run ? FS_FETCH_T0 : FS_IDLE;
      FS_FAULT:    w_state_next = FS_FAULT;
      default:     w_state_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      r_instr_count <= '0;
    end else if (r_state == FS_FETCH_T2) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign PCout       = w_strobes.pc_out;
  assign MARin       = w_strobes.mar_in;
  assign IncPC       = w_strobes.inc_pc;
  assign Read        = w_strobes.read;
  assign MDRin       = w_strobes.mdr_in;
  assign MDRout      = w_strobes.mdr_out;
  assign IRin        = w_strobes.ir_in;
  assign PCin        = w_strobes.pc_in;
  assign TargetOut   = w_strobes.target_out;
  assign instr_valid = (r_state == FS_ISSUE);
  assign busy        = (r_state != FS_IDLE) && (r_state != FS_FAULT);
  assign fault       = (r_state == FS_FAULT);
  assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer : randomized self-checking bench; expected cycle traces
//                      are expanded from per-instruction descriptions.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  localparam int TO = 15;

  // {PCout,MARin,IncPC,Read,MDRin,MDRout,IRin,PCin,TargetOut, instr_valid,busy,fault}
  localparam logic [11:0] V_IDLE  = 12'b000000000_000;
  localparam logic [11:0] V_T0    = 12'b111000000_010;
  localparam logic [11:0] V_MW    = 12'b000100000_010;
  localparam logic [11:0] V_MWR   = 12'b000110000_010;
  localparam logic [11:0] V_T2    = 12'b000001100_010;
  localparam logic [11:0] V_ISS   = 12'b000000000_110;
  localparam logic [11:0] V_EX    = 12'b000000000_010;
  localparam logic [11:0] V_BR    = 12'b000000011_010;
  localparam logic [11:0] V_FAULT = 12'b000000000_001;

  logic Clock = 1'b0;
  logic Clear_n, run, mem_ready, exec_ready, exec_done, branch_taken;
  logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, PCin, TargetOut;
  logic instr_valid, busy, fault;
  logic [31:0] instr_count;
  logic [11:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  assign obs = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, PCin, TargetOut,
                instr_valid, busy, fault};

  fetch_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .Clock(Clock), .Clear_n(Clear_n), .run(run), .mem_ready(mem_ready),
    .exec_ready(exec_ready), .exec_done(exec_done), .branch_taken(branch_taken),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .PCin(PCin), .TargetOut(TargetOut),
    .instr_valid(instr_valid), .busy(busy), .fault(fault), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  // md: mem_ready-low cycles before data (>= TO means never), rd/dd: stall
  // cycles before exec_ready/exec_done, run_mid: run level while in flight,
  // run_end: run level at the exec_done / branch decision.
  typedef struct { int md; int rd; int dd; bit br; bit run_mid; bit run_end; } instr_t;
  typedef struct { bit run; bit mr; bit er; bit ed; bit bt; logic [11:0] vec; logic [31:0] cnt; } cyc_t;

  cyc_t        trace[$];
  logic [11:0] obs_vec[$];
  logic [31:0] obs_cnt[$];
  logic [31:0] m_cnt;

  function automatic bit rb();
    return bit'($urandom % 2);
  endfunction

  function automatic instr_t mk(int md, int rd, int dd, bit br, bit rm, bit re);
    instr_t p;
    p.md = md; p.rd = rd; p.dd = dd; p.br = br; p.run_mid = rm; p.run_end = re;
    return p;
  endfunction

  task automatic add(input bit r, input bit mr, input bit er, input bit ed,
                     input bit bt, input logic [11:0] v);
    cyc_t c;
    c.run = r; c.mr = mr; c.er = er; c.ed = ed; c.bt = bt; c.vec = v; c.cnt = m_cnt;
    trace.push_back(c);
  endtask

  // Expand a program into the cycle-by-cycle stimulus and expected outputs,
  // starting from IDLE. Inputs the FSM must ignore get random values.
  task automatic build(input instr_t prog[$]);
    trace.delete();
    add(1'b1, rb(), rb(), rb(), rb(), V_IDLE);
    foreach (prog[i]) begin
      instr_t p;
      p = prog[i];
      add(p.run_mid, rb(), rb(), rb(), rb(), V_T0);
      if (p.md >= TO) begin
        for (int k = 0; k < TO; k++) add(p.run_mid, 1'b0, rb(), rb(), rb(), V_MW);
        for (int k = 0; k < 3; k++)  add(rb(), rb(), rb(), rb(), rb(), V_FAULT);
        return;
      end
      for (int k = 0; k < p.md; k++) add(p.run_mid, 1'b0, rb(), rb(), rb(), V_MW);
      add(p.run_mid, 1'b1, rb(), rb(), rb(), V_MWR);
      add(p.run_mid, rb(), rb(), rb(), rb(), V_T2);
      m_cnt = m_cnt + 32'd1;
      for (int k = 0; k < p.rd; k++) add(p.run_mid, rb(), 1'b0, rb(), rb(), V_ISS);
      add(p.run_mid, rb(), 1'b1, rb(), rb(), V_ISS);
      for (int k = 0; k < p.dd; k++) add(p.run_mid, rb(), rb(), 1'b0, rb(), V_EX);
      add(p.run_end, rb(), rb(), 1'b1, p.br, V_EX);
      if (p.br) add(p.run_end, rb(), rb(), rb(), rb(), V_BR);
      if (!p.run_end) add(i != prog.size() - 1, rb(), rb(), rb(), rb(), V_IDLE);
    end
  endtask

  task automatic play(input int n);
    obs_vec.delete();
    obs_cnt.delete();
    foreach (trace[i]) begin
      if (n >= 0 && i >= n) break;
      @(negedge Clock);
      run = trace[i].run; mem_ready = trace[i].mr; exec_ready = trace[i].er;
      exec_done = trace[i].ed; branch_taken = trace[i].bt;
      #1;
      obs_vec.push_back(obs);
      obs_cnt.push_back(instr_count);
    end
  endtask

  task automatic test_reset();
    Clear_n = 1'b0;
    @(posedge Clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      run = rb(); mem_ready = rb(); exec_ready = rb(); exec_done = rb(); branch_taken = rb();
      #1;
      n_checks++;
      if (obs !== V_IDLE) begin
        n_fail++; $display("FAIL reset_outputs cycle %0d: got %b, want %b", k, obs, V_IDLE);
      end
      n_checks++;
      if (instr_count !== 32'd0) begin
        n_fail++; $display("FAIL reset_count cycle %0d: got %h, want 0", k, instr_count);
      end
    end
    @(negedge Clock);
    Clear_n = 1'b1; run = 1'b0;
    m_cnt = 32'd0;
  endtask

  task automatic test_basic();
    instr_t q[$];
    q.push_back(mk(0, 0, 1, 1'b0, 1'b1, 1'b1));
    q.push_back(mk(0, 0, 0, 1'b0, 1'b1, 1'b0));
    build(q); play(-1);
    foreach (obs_vec[i]) begin
      n_checks++;
      if (obs_vec[i] !== trace[i].vec) begin
        n_fail++; $display("FAIL basic_strobes cycle %0d: got %b, want %b", i, obs_vec[i], trace[i].vec);
      end
      n_checks++;
      if (obs_cnt[i] !== trace[i].cnt) begin
        n_fail++; $display("FAIL basic_count cycle %0d: got %h, want %h", i, obs_cnt[i], trace[i].cnt);
      end
    end
  endtask

  task automatic test_mem_delay();
    instr_t q[$];
    q.push_back(mk(3, 0, 0, 1'b0, 1'b1, 1'b1));
    q.push_back(mk(TO - 1, 1, 0, 1'b0, 1'b1, 1'b0));
    build(q); play(-1);
    foreach (obs_vec[i]) begin
      n_checks++;
      if (obs_vec[i] !== trace[i].vec) begin
        n_fail++; $display("FAIL memdelay_strobes cycle %0d: got %b, want %b", i, obs_vec[i], trace[i].vec);
      end
      n_checks++;
      if (obs_cnt[i] !== trace[i].cnt) begin
        n_fail++; $display("FAIL memdelay_count cycle %0d: got %h, want %h", i, obs_cnt[i], trace[i].cnt);
      end
    end
  endtask

  task automatic test_branch();
    instr_t q[$];
    q.push_back(mk(1, 0, 2, 1'b1, 1'b1, 1'b1));
    q.push_back(mk(0, 2, 0, 1'b1, 1'b1, 1'b0));
    build(q); play(-1);
    foreach (obs_vec[i]) begin
      n_checks++;
      if (obs_vec[i] !== trace[i].vec) begin
        n_fail++; $display("FAIL branch_strobes cycle %0d: got %b, want %b", i, obs_vec[i], trace[i].vec);
      end
      n_checks++;
      if (obs_cnt[i] !== trace[i].cnt) begin
        n_fail++; $display("FAIL branch_count cycle %0d: got %h, want %h", i, obs_cnt[i], trace[i].cnt);
      end
    end
  endtask

  task automatic test_run_drop();
    instr_t q[$];
    q.push_back(mk(2, 1, 1, 1'b0, 1'b0, 1'b0));
    build(q); play(-1);
    foreach (obs_vec[i]) begin
      n_checks++;
      if (obs_vec[i] !== trace[i].vec) begin
        n_fail++; $display("FAIL rundrop_strobes cycle %0d: got %b, want %b", i, obs_vec[i], trace[i].vec);
      end
      n_checks++;
      if (obs_cnt[i] !== trace[i].cnt) begin
        n_fail++; $display("FAIL rundrop_count cycle %0d: got %h, want %h", i, obs_cnt[i], trace[i].cnt);
      end
    end
  endtask

  task automatic test_timeout();
    instr_t q[$];
    q.push_back(mk(0, 0, 0, 1'b0, 1'b1, 1'b1));
    q.push_back(mk(TO, 0, 0, 1'b0, 1'b1, 1'b1));
    build(q); play(-1);
    foreach (obs_vec[i]) begin
      n_checks++;
      if (obs_vec[i] !== trace[i].vec) begin
        n_fail++; $display("FAIL timeout_strobes cycle %0d: got %b, want %b", i, obs_vec[i], trace[i].vec);
      end
      n_checks++;
      if (obs_cnt[i] !== trace[i].cnt) begin
        n_fail++; $display("FAIL timeout_count cycle %0d: got %h, want %h", i, obs_cnt[i], trace[i].cnt);
      end
    end
    @(negedge Clock);
    Clear_n = 1'b0; run = 1'b1;
    @(negedge Clock);
    Clear_n = 1'b1; run = 1'b0;
    #1;
    m_cnt = 32'd0;
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL fault_clear_outputs: got %b, want %b", obs, V_IDLE);
    end
    n_checks++;
    if (instr_count !== 32'd0) begin
      n_fail++; $display("FAIL fault_clear_count: got %h, want 0", instr_count);
    end
  endtask

  task automatic test_reset_midwait();
    instr_t q[$];
    q.push_back(mk(8, 0, 0, 1'b0, 1'b1, 1'b0));
    m_cnt = 32'd0;
    build(q); play(6);
    @(negedge Clock);
    Clear_n = 1'b0;
    @(negedge Clock);
    Clear_n = 1'b1; run = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL midwait_reset_outputs: got %b, want %b", obs, V_IDLE);
    end
    m_cnt = 32'd0;
    q.delete();
    q.push_back(mk(TO - 1, 0, 0, 1'b0, 1'b1, 1'b0));
    build(q); play(-1);
    foreach (obs_vec[i]) begin
      n_checks++;
      if (obs_vec[i] !== trace[i].vec) begin
        n_fail++; $display("FAIL midwait_strobes cycle %0d: got %b, want %b", i, obs_vec[i], trace[i].vec);
      end
    end
  endtask

  task automatic test_wrap();
    instr_t q[$];
    @(negedge Clock);
    force dut.r_instr_count = 32'hFFFF_FFFF;
    @(negedge Clock);
    release dut.r_instr_count;
    #1;
    n_checks++;
    if (instr_count !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_preload: got %h, want ffffffff", instr_count);
    end
    m_cnt = 32'hFFFF_FFFF;
    q.push_back(mk(1, 0, 0, 1'b0, 1'b1, 1'b0));
    build(q); play(-1);
    foreach (obs_vec[i]) begin
      n_checks++;
      if (obs_cnt[i] !== trace[i].cnt) begin
        n_fail++; $display("FAIL wrap_count cycle %0d: got %h, want %h", i, obs_cnt[i], trace[i].cnt);
      end
    end
  endtask

  task automatic test_random();
    instr_t q[$];
    for (int k = 0; k < 12; k++) begin
      q.push_back(mk(int'($urandom_range(TO - 1, 0)), int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)), rb(), rb(), (k == 11) ? 1'b0 : rb()));
    end
    build(q); play(-1);
    foreach (obs_vec[i]) begin
      n_checks++;
      if (obs_vec[i] !== trace[i].vec) begin
        n_fail++; $display("FAIL random_strobes cycle %0d: got %b, want %b", i, obs_vec[i], trace[i].vec);
      end
      n_checks++;
      if (obs_cnt[i] !== trace[i].cnt) begin
        n_fail++; $display("FAIL random_count cycle %0d: got %h, want %h", i, obs_cnt[i], trace[i].cnt);
      end
    end
  endtask

  initial begin
    Clear_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
    exec_ready = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;
    m_cnt = 32'd0;
    test_reset();
    test_basic();
    test_mem_delay();
    test_branch();
    test_run_drop();
    test_timeout();
    test_reset_midwait();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
